// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage hazard controller bundle: ID instruction fields, release
// channel and the interlock/debug outputs.
interface id_hazard_ctrl_if #(
  parameter int unsigned PERF_W = 16
);
  localparam int unsigned REG_W = 3;
  localparam int unsigned ST_W  = 2;

  logic             id_valid;
  logic [REG_W-1:0] id_sr1;
  logic             id_use_sr1;
  logic [REG_W-1:0] id_sr2;
  logic             id_use_sr2;
  logic             id_use_cc;
  logic [REG_W-1:0] id_dest;
  logic             id_wr_dest;
  logic             id_wr_cc;
  logic             id_serial;
  logic             pipe_stall;
  logic             flush;
  logic             rel_valid;
  logic [REG_W-1:0] rel_dest;
  logic             rel_wr_dest;
  logic             rel_wr_cc;

  logic              issue;
  logic              hold_ifid;
  logic              bubble;
  logic              busy;
  logic [ST_W-1:0]   state;
  logic [PERF_W-1:0] stall_cycles;
  logic              sb_err;

  modport master (
    output id_valid, id_sr1, id_use_sr1, id_sr2, id_use_sr2, id_use_cc,
           id_dest, id_wr_dest, id_wr_cc, id_serial, pipe_stall, flush,
           rel_valid, rel_dest, rel_wr_dest, rel_wr_cc,
    input  issue, hold_ifid, bubble, busy, state, stall_cycles, sb_err
  );

  modport slave (
    input  id_valid, id_sr1, id_use_sr1, id_sr2, id_use_sr2, id_use_cc,
           id_dest, id_wr_dest, id_wr_cc, id_serial, pipe_stall, flush,
           rel_valid, rel_dest, rel_wr_dest, rel_wr_cc,
    output issue, hold_ifid, bubble, busy, state, stall_cycles, sb_err
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// LC-3b decode-stage scoreboard: counts in-flight register/CC writes and
// decides issue, IF/ID hold and ID/EX bubble each cycle.
module id_hazard_ctrl #(
  parameter int unsigned PEND_W = 2,
  parameter int unsigned PERF_W = 16
) (
  input logic             clk,
  input logic             rst,
  id_hazard_ctrl_if.slave bus
);
  localparam int unsigned NREG  = 8;
  localparam int unsigned REG_W = 3;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } state_e;

  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic [PEND_W-1:0] cc_pend_q, cc_pend_d;
  state_e            state_q, state_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              sb_err_q, sb_err_d;

  logic            busy_c, hazard_c, live_c, issue_c, hold_c, bubble_c;
  logic [NREG-1:0] inc_c, dec_c;
  logic            cc_inc_c, cc_dec_c;

  // Any outstanding register or CC reservation
  always_comb begin
    busy_c = (cc_pend_q != '0);
    for (int unsigned r = 0; r < NREG; r++) begin
      busy_c = busy_c | (pend_q[r] != '0);
    end
  end

  // Interlock decision; flush squashes the ID op and releases the hold
  always_comb begin
    live_c   = bus.id_valid & ~bus.flush;
    hazard_c = (bus.id_use_sr1 & (pend_q[bus.id_sr1] != '0))
             | (bus.id_use_sr2 & (pend_q[bus.id_sr2] != '0))
             | (bus.id_use_cc  & (cc_pend_q != '0))
             | (bus.id_wr_dest & (pend_q[bus.id_dest] == PEND_MAX))
             | (bus.id_wr_cc   & (cc_pend_q == PEND_MAX))
             | (bus.id_serial  & busy_c);
    issue_c  = live_c & ~bus.pipe_stall & ~hazard_c;
    hold_c   = ~bus.flush & (bus.pipe_stall | (bus.id_valid & hazard_c));
    bubble_c = ~issue_c & ~bus.pipe_stall;
  end

  // Reservation counters; a release to an empty counter is absorbed and flagged
  always_comb begin
    inc_c    = '0;
    dec_c    = '0;
    sb_err_d = sb_err_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      inc_c[r]  = issue_c & bus.id_wr_dest & (bus.id_dest == REG_W'(r));
      dec_c[r]  = bus.rel_valid & bus.rel_wr_dest & (bus.rel_dest == REG_W'(r));
      pend_d[r] = pend_q[r];
      if (dec_c[r] && (pend_q[r] == '0)) begin
        sb_err_d = 1'b1;
      end else if (inc_c[r] && !dec_c[r]) begin
        pend_d[r] = pend_q[r] + PEND_W'(1);
      end else if (dec_c[r] && !inc_c[r]) begin
        pend_d[r] = pend_q[r] - PEND_W'(1);
      end
    end

    cc_inc_c  = issue_c & bus.id_wr_cc;
    cc_dec_c  = bus.rel_valid & bus.rel_wr_cc;
    cc_pend_d = cc_pend_q;
    if (cc_dec_c && (cc_pend_q == '0)) begin
      sb_err_d = 1'b1;
    end else if (cc_inc_c && !cc_dec_c) begin
      cc_pend_d = cc_pend_q + PEND_W'(1);
    end else if (cc_dec_c && !cc_inc_c) begin
      cc_pend_d = cc_pend_q - PEND_W'(1);
    end
  end

  // Debug FSM and saturating stall-cycle counter
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      RUN: begin
        if (live_c & bus.id_serial & busy_c) begin
          state_d = DRAIN;
        end else if (live_c & hazard_c) begin
          state_d = STALL;
        end
      end
      STALL, DRAIN: begin
        if (issue_c | bus.flush) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (live_c & ~bus.pipe_stall & hazard_c & (stall_cnt_q != PERF_MAX)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        pend_q[r] <= '0;
      end
      cc_pend_q   <= '0;
      state_q     <= RUN;
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        pend_q[r] <= pend_d[r];
      end
      cc_pend_q   <= cc_pend_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign bus.issue        = issue_c;
  assign bus.hold_ifid    = hold_c;
  assign bus.bubble       = bubble_c;
  assign bus.busy         = busy_c;
  assign bus.state        = 2'(state_q);
  assign bus.stall_cycles = stall_cnt_q;
  assign bus.sb_err       = sb_err_q;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed hazard scenarios followed by random
// traffic, checked against an in-flight instruction list model.
module tb_id_hazard_ctrl;
  localparam int unsigned PERF_W = 16;
  localparam int MAXP = 3;
  localparam int PERF_SAT = 65535;

  logic clk = 1'b0;
  logic rst;

  id_hazard_ctrl_if #(.PERF_W(PERF_W)) bus ();

  id_hazard_ctrl #(.PEND_W(2), .PERF_W(PERF_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] dest;
    logic       wd;
    logic       wc;
  } inf_t;

  inf_t infl[$];
  int   m_state;
  int   m_stall;
  bit   m_err;
  int   checks   = 0;
  int   failures = 0;

  logic       o_issue, o_hold, o_bubble;
  logic [1:0] o_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int n_reg(input logic [2:0] r);
    int n = 0;
    foreach (infl[i]) if (infl[i].wd && infl[i].dest == r) n++;
    return n;
  endfunction

  function automatic int n_cc();
    int n = 0;
    foreach (infl[i]) if (infl[i].wc) n++;
    return n;
  endfunction

  function automatic bit m_hazard();
    return (bus.id_use_sr1 && n_reg(bus.id_sr1) > 0)
        || (bus.id_use_sr2 && n_reg(bus.id_sr2) > 0)
        || (bus.id_use_cc  && n_cc() > 0)
        || (bus.id_wr_dest && n_reg(bus.id_dest) >= MAXP)
        || (bus.id_wr_cc   && n_cc() >= MAXP)
        || (bus.id_serial  && infl.size() > 0);
  endfunction

  task automatic set_ins(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                         input bit ucc, input int d, input bit wd, input bit wc, input bit ser);
    bus.id_valid   = v;
    bus.id_sr1     = 3'(s1);
    bus.id_use_sr1 = u1;
    bus.id_sr2     = 3'(s2);
    bus.id_use_sr2 = u2;
    bus.id_use_cc  = ucc;
    bus.id_dest    = 3'(d);
    bus.id_wr_dest = wd;
    bus.id_wr_cc   = wc;
    bus.id_serial  = ser;
  endtask

  task automatic set_rel(input bit rv, input int d, input bit wd, input bit wc);
    bus.rel_valid   = rv;
    bus.rel_dest    = 3'(d);
    bus.rel_wr_dest = wd;
    bus.rel_wr_cc   = wc;
  endtask

  task automatic set_ctl(input bit ps, input bit fl);
    bus.pipe_stall = ps;
    bus.flush      = fl;
  endtask

  task automatic idle();
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_rel(0, 0, 0, 0);
    set_ctl(0, 0);
  endtask

  // Async reset checked before any clock edge, then released at a falling edge
  task automatic do_reset();
    rst = 1'b1;
    idle();
    #2;
    infl.delete();
    m_state = 0;
    m_stall = 0;
    m_err   = 0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_stall_cycles", bus.stall_cycles, 0);
    chk("rst_sb_err", bus.sb_err, 0);
    chk("rst_issue", bus.issue, 0);
    chk("rst_hold", bus.hold_ifid, 0);
    chk("rst_bubble", bus.bubble, 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: check decisions against the model, advance model, check registers
  task automatic cycle();
    bit hz, live, iss, hold, bub, found;
    int nxt;
    #1;
    hz   = m_hazard();
    live = bus.id_valid && !bus.flush;
    iss  = live && !bus.pipe_stall && !hz;
    hold = !bus.flush && (bus.pipe_stall || (bus.id_valid && hz));
    bub  = !iss && !bus.pipe_stall;
    o_issue  = bus.issue;
    o_hold   = bus.hold_ifid;
    o_bubble = bus.bubble;
    chk("issue", bus.issue, iss);
    chk("hold_ifid", bus.hold_ifid, hold);
    chk("bubble", bus.bubble, bub);
    chk("busy", bus.busy, infl.size() > 0);

    nxt = m_state;
    if (m_state == 0) begin
      if (live && bus.id_serial && infl.size() > 0) nxt = 2;
      else if (live && hz) nxt = 1;
    end else if (iss || bus.flush) begin
      nxt = 0;
    end
    m_state = nxt;
    if (live && !bus.pipe_stall && hz && m_stall < PERF_SAT) m_stall++;
    if (bus.rel_valid) begin
      if (bus.rel_wr_dest && n_reg(bus.rel_dest) == 0) m_err = 1;
      if (bus.rel_wr_cc && n_cc() == 0) m_err = 1;
      found = 0;
      for (int i = 0; i < infl.size(); i++) begin
        if (!found && infl[i].wd == bus.rel_wr_dest && infl[i].wc == bus.rel_wr_cc &&
            (!bus.rel_wr_dest || infl[i].dest == bus.rel_dest)) begin
          infl.delete(i);
          found = 1;
        end
      end
    end
    if (iss && (bus.id_wr_dest || bus.id_wr_cc))
      infl.push_back('{dest: bus.id_dest, wd: bus.id_wr_dest, wc: bus.id_wr_cc});

    @(posedge clk);
    #1;
    o_state = bus.state;
    chk("state", bus.state, m_state);
    chk("stall_cycles", bus.stall_cycles, m_stall);
    chk("sb_err", bus.sb_err, m_err);
    chk("busy_post", bus.busy, infl.size() > 0);
    @(negedge clk);
  endtask

  initial begin
    bit have;
    bit fl;
    int idx;
    rst = 1'b1;
    idle();
    do_reset();

    // RAW on R1: dependent op waits for the release, issues the cycle after
    set_ins(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); cycle();
    chk("raw_first_issue", o_issue, 1);
    set_ins(1, 1, 1, 2, 1, 0, 5, 0, 0, 0); cycle();
    chk("raw_hold", o_hold, 1);
    chk("raw_bubble", o_bubble, 1);
    chk("raw_state_stall", o_state, 1);
    cycle();
    set_rel(1, 1, 1, 0); cycle();
    chk("raw_no_bypass", o_issue, 0);
    set_rel(0, 0, 0, 0); cycle();
    chk("raw_issue_after_rel", o_issue, 1);
    chk("raw_stall_count", bus.stall_cycles, 3);
    chk("raw_state_run", o_state, 0);

    // Same-cycle issue and release on R3 leaves one reservation
    do_reset();
    set_ins(1, 0, 0, 0, 0, 0, 3, 1, 0, 0); cycle();
    set_rel(1, 3, 1, 0); cycle();
    chk("r3_issue_with_rel", o_issue, 1);
    set_rel(0, 0, 0, 0);
    set_ins(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("r3_still_pending", o_issue, 0);
    set_rel(1, 3, 1, 0); cycle();
    set_rel(0, 0, 0, 0); cycle();
    chk("r3_reader_issue", o_issue, 1);

    // CC dependency, then CC writer saturation
    do_reset();
    set_ins(1, 0, 0, 0, 0, 0, 0, 1, 1, 0); cycle();
    set_ins(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); cycle();
    chk("br_stall", o_issue, 0);
    cycle();
    set_rel(1, 0, 1, 1); cycle();
    set_rel(0, 0, 0, 0); cycle();
    chk("br_issue", o_issue, 1);
    set_ins(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("cc_writer_issue", o_issue, 1);
    end
    cycle();
    chk("cc_sat_stall", o_issue, 0);
    chk("cc_sat_hold", o_hold, 1);

    // Serializing op drains two loads
    do_reset();
    set_ins(1, 0, 0, 0, 0, 0, 2, 1, 0, 0); cycle();
    set_ins(1, 0, 0, 0, 0, 0, 4, 1, 0, 0); cycle();
    set_ins(1, 0, 0, 0, 0, 0, 7, 1, 0, 1); cycle();
    chk("trap_wait", o_issue, 0);
    chk("trap_drain", o_state, 2);
    set_rel(1, 2, 1, 0); cycle();
    chk("trap_drain2", o_state, 2);
    set_rel(1, 4, 1, 0); cycle();
    chk("trap_no_bypass", o_issue, 0);
    set_rel(0, 0, 0, 0); cycle();
    chk("trap_issue", o_issue, 1);
    chk("trap_run", o_state, 0);

    // Flush with pipe_stall during STALL; then release with nothing pending
    do_reset();
    set_ins(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); cycle();
    set_ins(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("fl_stalled", o_state, 1);
    set_ctl(1, 1); cycle();
    chk("fl_issue", o_issue, 0);
    chk("fl_hold", o_hold, 0);
    chk("fl_state", o_state, 0);
    set_ctl(0, 0); cycle();
    chk("fl_pend_kept", o_issue, 0);
    idle();
    set_rel(1, 6, 1, 0); cycle();
    chk("sb_err_set", bus.sb_err, 1);
    set_rel(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle();
    chk("sb_err_sticky", bus.sb_err, 1);

    // Reset while stalled with three registers pending
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      set_ins(1, 0, 0, 0, 0, 0, k, 1, 0, 0); cycle();
    end
    set_ins(1, 2, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
    chk("pre_rst_state", o_state, 1);
    chk("pre_rst_busy", bus.busy, 1);
    do_reset();

    // Random traffic; an ID op stays put until it issues or is flushed
    have = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) begin
        do_reset();
        have = 0;
      end
      if (!have) begin
        have = ($urandom_range(0, 9) < 8);
        set_ins(have, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 3),
                $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
      end
      fl = ($urandom_range(0, 99) < 8);
      set_ctl($urandom_range(0, 99) < 15, fl);
      if (infl.size() > 0 && $urandom_range(0, 99) < 40) begin
        idx = $urandom_range(0, infl.size() - 1);
        set_rel(1, int'(infl[idx].dest), infl[idx].wd, infl[idx].wc);
      end else begin
        set_rel(0, 0, 0, 0);
      end
      cycle();
      if (o_issue || fl) have = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
